pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Generic, parameterised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It replaces the fixed-field, stall/flush-only decode→execute register with a single reusable stage, instantiated between any two core pipeline stages (fetch/decode, decode/execute, execute/memory). Backpressure is absorbed without a combinational ready path from downstream to upstream. Flush kills all in-flight entries.

## Interface
Parameters:
- CTRLW, 8 — control-bit field width (alu_op, reg_wr_en, mem_wr_en, branch, fft_wr_en, use_imm, …)
- DATAW, 32 — operand width (a, b)
- PCW, 32 — program counter width
- IMMW, 11 — immediate width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill all entries held in this stage
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; registered-state only, no path from out_ready
- in_ctrl  in  CTRLW  control bits
- in_a, in_b  in  DATAW  operands
- in_pc  in  PCW  PC of entry
- in_imm  in  IMMW  immediate
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl, out_a, out_b, out_pc, out_imm  out  as inputs  presented entry
- stall_cnt  out  16  cycles with out_valid & !out_ready (see Configuration)
- bubble_cnt  out  16  cycles with !out_valid (see Configuration)

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives outputs) and skid register.
- States: EMPTY (neither valid), ONE (main valid), FULL (main + skid valid).
- EMPTY: in_fire → main←in, ONE.
- ONE: in_fire & out_fire → main←in, stay ONE; in_fire only → skid←in, FULL; out_fire only → EMPTY; neither → hold.
- FULL: in_ready=0; out_fire → main←skid, ONE; else hold.
- in_ready = (state != FULL) & !rst.
- out_valid = (state != EMPTY).
- out_ctrl forced to 0 whenever out_valid=0, so a bubble never writes. Data fields hold their last value.
- Entry order is strictly FIFO; no entry is duplicated or dropped except by flush/rst.

## Timing
- rst (priority 1): state EMPTY; all main/skid payload zero; out_valid=0; in_ready=0 during rst, 1 the first cycle after; counters 0.
- flush (priority 2): next cycle state EMPTY; main/skid payload zeroed; an in_fire in the same cycle is dropped; out_fire in the same cycle still counts downstream. Counters unaffected.
- Latency: in_fire at cycle N → out_valid at N+1.
- Throughput: 1 entry/cycle when out_ready held high.
- in_ready deasserts the cycle after entering FULL. At most one entry is accepted after out_ready drops.
- Payload changes on the output only on a cycle following out_fire or a load from EMPTY. It stays stable while out_valid & !out_ready.

## Configuration
- PIPE_STAGE_PERF_EN defined: stall_cnt and bubble_cnt increment on their conditions.
  - Counters saturate at 16'hFFFF.
  - They are cleared only by rst.
- Undefined: no counter flops; stall_cnt and bubble_cnt tied to 0. Ports remain present.

## Structure
- pipe_pkg: typedef pipe_state_t enum {PS_EMPTY=2'b00, PS_ONE=2'b01, PS_FULL=2'b10}.
- pipe_pkg: parameterised-width payload packing helpers; default width constants.
- Sub-module sat_counter (16-bit saturating up-counter with sync clear), instantiated twice, only under PIPE_STAGE_PERF_EN.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1, in_a=32'h1234.
  - During rst: in_ready=0.
  - After rst: out_valid=0, out_ctrl=0, all outputs 0.
  - Next cycle: in_ready=1.
- Streaming: out_ready=1, send 8 entries pc=0..7 back-to-back → out_pc=0..7 on consecutive cycles, 1-cycle latency, in_ready never drops.
- Backpressure: during a stream, out_ready=0 for 4 cycles.
  - in_ready falls after exactly 2 entries are held.
  - out_pc stable throughout.
  - On release, entries emerge in order with no loss or duplication.
- Flush in FULL: state FULL, assert flush with in_valid=1 → next cycle out_valid=0, out_ctrl=0, in_ready=1; flushed and same-cycle inputs never appear.
- Simultaneous fire in ONE: in_fire & out_fire for 5 cycles → state stays ONE, skid never used.
- Counters (PERF_EN): 3 stall cycles then 70000 idle cycles → stall_cnt=3, bubble_cnt=16'hFFFF; flush leaves both unchanged; rst zeroes both.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: state encoding, default widths and payload sizing helper for pipe_stage_skid.
package pipe_pkg;
  typedef enum logic [1:0] {PS_EMPTY = 2'b00, PS_ONE = 2'b01, PS_FULL = 2'b10} pipe_state_t;
  localparam int PIPE_CTRLW = 8;
  localparam int PIPE_DATAW = 32;
  localparam int PIPE_PCW = 32;
  localparam int PIPE_IMMW = 11;
  localparam int CNTW = 16;
  function automatic int payload_w(input int ctrlw, input int dataw, input int pcw, input int immw);
    return ctrlw + 2 * dataw + pcw + immw;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: 16-bit saturating up-counter, cleared by synchronous rst.
module sat_counter
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_i,
  output logic [CNTW-1:0] cnt_o
);
  logic [CNTW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble performance counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRLW = PIPE_CTRLW,
  parameter int DATAW = PIPE_DATAW,
  parameter int PCW   = PIPE_PCW,
  parameter int IMMW  = PIPE_IMMW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTRLW-1:0] in_ctrl,
  input  logic [DATAW-1:0] in_a,
  input  logic [DATAW-1:0] in_b,
  input  logic [PCW-1:0]   in_pc,
  input  logic [IMMW-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTRLW-1:0] out_ctrl,
  output logic [DATAW-1:0] out_a,
  output logic [DATAW-1:0] out_b,
  output logic [PCW-1:0]   out_pc,
  output logic [IMMW-1:0]  out_imm,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      bubble_cnt
);
  localparam int PW = payload_w(CTRLW, DATAW, PCW, IMMW);
  pipe_state_t state_q, state_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;
  logic [CTRLW-1:0] main_ctrl;
  logic in_fire, out_fire;
  assign in_pl = {in_ctrl, in_a, in_b, in_pc, in_imm};
  assign in_ready = (state_q != PS_FULL) & ~rst;
  assign out_valid = (state_q != PS_EMPTY);
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign {main_ctrl, out_a, out_b, out_pc, out_imm} = main_q;
  // A bubble must never carry live control bits downstream.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      main_d = '0;
      skid_d = '0;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          state_d = in_fire ? PS_ONE : PS_EMPTY;
          main_d = in_fire ? in_pl : main_q;
        end
        PS_ONE: begin
          state_d = (in_fire & ~out_fire) ? PS_FULL : (~in_fire & out_fire) ? PS_EMPTY : PS_ONE;
          main_d = (in_fire & out_fire) ? in_pl : main_q;
          skid_d = (in_fire & ~out_fire) ? in_pl : skid_q;
        end
        PS_FULL: begin
          state_d = out_fire ? PS_ONE : PS_FULL;
          main_d = out_fire ? skid_q : main_q;
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= PS_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
`ifdef PIPE_STAGE_PERF_EN
  sat_counter u_stall (.clk(clk), .rst(rst), .inc_i(out_valid & ~out_ready), .cnt_o(stall_cnt));
  sat_counter u_bubble (.clk(clk), .rst(rst), .inc_i(~out_valid), .cnt_o(bubble_cnt));
`else
  assign stall_cnt = '0;
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed self-checking bench for pipe_stage_skid.
module tb_pipe_stage_skid;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [7:0] in_ctrl = 0, out_ctrl;
  logic [31:0] in_a = 0, in_b = 0, in_pc = 0, out_a, out_b, out_pc;
  logic [10:0] in_imm = 0, out_imm;
  logic [15:0] stall_cnt, bubble_cnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_a(out_a),
    .out_b(out_b), .out_pc(out_pc), .out_imm(out_imm), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );
  function automatic logic [7:0] ctrl_of(input int pc);
    return 8'(pc) | 8'h80;
  endfunction
  task automatic set_in(input logic v, input int pc);
    in_valid = v;
    in_pc = 32'(pc);
    in_a = 32'(pc * 5);
    in_b = ~32'(pc);
    in_ctrl = ctrl_of(pc);
    in_imm = 11'(pc);
  endtask
  task automatic do_reset();
    rst = 1; flush = 0; out_ready = 0;
    set_in(1, 0);
    in_a = 32'h1234;
    repeat (3) @(negedge clk);
    rst = 0;
    set_in(0, 0);
  endtask
  task automatic test_reset();
    rst = 1; set_in(1, 0); in_a = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready cyc%0d got=%b exp=0", i, in_ready); end
    end
    total++;
    if ({out_valid, out_ctrl, out_a, out_b, out_pc, out_imm} !== '0) begin
      bad++; $display("FAIL reset_outputs got v=%b c=%h a=%h b=%h pc=%h imm=%h exp all 0", out_valid, out_ctrl, out_a, out_b, out_pc, out_imm);
    end
    rst = 0; set_in(0, 0);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h0) begin bad++; $display("FAIL reset_post_out got v=%b c=%h exp v=0 c=0", out_valid, out_ctrl); end
  endtask
  task automatic test_streaming();
    out_ready = 1;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready step%0d got=%b exp=1", i, in_ready); end
      if (i >= 1 && i <= 8) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'(i - 1) || out_ctrl !== ctrl_of(i - 1) || out_a !== 32'((i - 1) * 5) || out_b !== ~32'(i - 1)) begin
          bad++; $display("FAIL stream_out step%0d got v=%b pc=%0d c=%h a=%0d exp v=1 pc=%0d c=%h a=%0d", i, out_valid, out_pc, out_ctrl, out_a, i - 1, ctrl_of(i - 1), (i - 1) * 5);
        end
      end
      if (i == 9) begin
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h0 || out_pc !== 32'd7) begin
          bad++; $display("FAIL stream_drain got v=%b c=%h pc=%0d exp v=0 c=0 pc=7", out_valid, out_ctrl, out_pc);
        end
      end
      set_in(i < 8, i);
    end
  endtask
  task automatic test_backpressure();
    logic ev[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int   ep[9] = '{0, 10, 10, 10, 10, 10, 11, 12, 0};
    logic er[9] = '{1, 1, 0, 0, 0, 0, 1, 1, 1};
    logic av[9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    int   ap[9] = '{10, 11, 12, 12, 12, 12, 12, 0, 0};
    logic ao[9] = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== ev[k] || in_ready !== er[k] || (ev[k] && (out_pc !== 32'(ep[k]) || out_ctrl !== ctrl_of(ep[k])))) begin
        bad++; $display("FAIL backpressure step%0d got v=%b rdy=%b pc=%0d exp v=%b rdy=%b pc=%0d", k, out_valid, in_ready, out_pc, ev[k], er[k], ep[k]);
      end
      set_in(av[k], ap[k]);
      out_ready = ao[k];
    end
  endtask
  task automatic test_flush_full();
    @(negedge clk); set_in(1, 20); out_ready = 0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'd20) begin bad++; $display("FAIL flush_setup got v=%b pc=%0d exp v=1 pc=20", out_valid, out_pc); end
    set_in(1, 21);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_pc !== 32'd20) begin bad++; $display("FAIL flush_full got rdy=%b pc=%0d exp rdy=0 pc=20", in_ready, out_pc); end
    flush = 1; set_in(1, 22); out_ready = 1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h0 || in_ready !== 1'b1 || out_pc !== 32'd0) begin
      bad++; $display("FAIL flush_after got v=%b c=%h rdy=%b pc=%0d exp v=0 c=0 rdy=1 pc=0", out_valid, out_ctrl, in_ready, out_pc);
    end
    flush = 0; set_in(0, 0);
    repeat (2) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost got v=%b pc=%0d exp v=0", out_valid, out_pc); end
    end
  endtask
  task automatic test_back_to_back();
    out_ready = 1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'(29 + i) || in_ready !== 1'b1) begin
          bad++; $display("FAIL b2b step%0d got v=%b pc=%0d rdy=%b exp v=1 pc=%0d rdy=1", i, out_valid, out_pc, in_ready, 29 + i);
        end
      end
      set_in(i < 6, 30 + i);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got v=%b exp v=0", out_valid); end
  endtask
  task automatic test_counters();
    do_reset();
    total++;
    if (stall_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin bad++; $display("FAIL cnt_reset got s=%0d b=%0d exp 0 0", stall_cnt, bubble_cnt); end
    set_in(1, 40); out_ready = 0;
    @(negedge clk); set_in(0, 0);
    repeat (3) @(negedge clk);
`ifdef PIPE_STAGE_PERF_EN
    total++;
    if (stall_cnt !== 16'd3 || bubble_cnt !== 16'd1) begin bad++; $display("FAIL cnt_stall got s=%0d b=%0d exp s=3 b=1", stall_cnt, bubble_cnt); end
    out_ready = 1;
    repeat (70001) @(negedge clk);
    total++;
    if (stall_cnt !== 16'd3 || bubble_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got s=%0d b=%h exp s=3 b=ffff", stall_cnt, bubble_cnt); end
    flush = 1; @(negedge clk); flush = 0; @(negedge clk);
    total++;
    if (stall_cnt !== 16'd3 || bubble_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_flush got s=%0d b=%h exp s=3 b=ffff", stall_cnt, bubble_cnt); end
    rst = 1; @(negedge clk);
    total++;
    if (stall_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin bad++; $display("FAIL cnt_rst got s=%0d b=%0d exp 0 0", stall_cnt, bubble_cnt); end
    rst = 0;
`else
    total++;
    if (stall_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin bad++; $display("FAIL cnt_tied got s=%0d b=%0d exp 0 0", stall_cnt, bubble_cnt); end
    out_ready = 1;
    @(negedge clk);
`endif
  endtask
  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_back_to_back();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
